// File: rtl/puertas_pkg.sv
// Door state, command and motor codes shared by the door controller, the door
// actuator and the car top level.
package puertas_pkg;

  // State encoding doubles as the puertas status code.
  typedef enum logic [1:0] {
    CERRADAS = 2'b00,
    ABIERTAS = 2'b01,
    CERRANDO = 2'b10,
    ABRIENDO = 2'b11
  } puertas_e;

  typedef enum logic [1:0] {
    NADA   = 2'b00,
    ABRIR  = 2'b01,
    CERRAR = 2'b10
  } cmd_e;

  typedef enum logic [1:0] {
    MOTOR_OFF    = 2'b00,
    MOTOR_ABRIR  = 2'b01,
    MOTOR_CERRAR = 2'b10
  } motor_e;

  function automatic motor_e motor_de(puertas_e s);
    motor_e m;
    m = MOTOR_OFF;
    if (s == ABRIENDO) begin
      m = MOTOR_ABRIR;
    end else if (s == CERRANDO) begin
      m = MOTOR_CERRAR;
    end
    return m;
  endfunction

endpackage

// File: rtl/motor_puertas_if.sv
// Door command/status bundle between the door controller (master) and the
// door actuator (slave).
interface motor_puertas_if;
  logic [1:0] salida_puertas;
  logic       sensor;
  logic [1:0] puertas;
  logic       timeout;
  logic [1:0] motor;

  modport master (
    output salida_puertas,
    output sensor,
    input  puertas,
    input  timeout,
    input  motor
  );

  modport slave (
    input  salida_puertas,
    input  sensor,
    output puertas,
    output timeout,
    output motor
  );
endinterface

// File: rtl/temporizador_puertas.sv
// Open-dwell timer: saturating counter with synchronous clear and count enable;
// the registered timeout flag is high while the count sits at T_OPEN.
module temporizador_puertas #(
  parameter int unsigned T_OPEN = 20,
  parameter int unsigned CW     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic timeout_o
);

  localparam logic [CW-1:0] TOpen = CW'(T_OPEN);
  localparam logic [CW-1:0] Uno   = CW'(1);

  logic [CW-1:0] dwell_q, dwell_d;
  logic          timeout_q, timeout_d;

  always_comb begin
    dwell_d = dwell_q;
    if (clr_i) begin
      dwell_d = '0;
    end else if (en_i && (dwell_q != TOpen)) begin
      dwell_d = dwell_q + Uno;
    end
    // Clear forces dwell to 0, and T_OPEN >= 1, so a clear also drops timeout.
    timeout_d = (dwell_d == TOpen);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q   <= '0;
      timeout_q <= 1'b0;
    end else begin
      dwell_q   <= dwell_d;
      timeout_q <= timeout_d;
    end
  end

  assign timeout_o = timeout_q;

endmodule

// File: rtl/motor_puertas.sv
// Door actuator for one car: travel position counter, door FSM with obstruction
// reversal, registered motor drive and the open-dwell timer.
module motor_puertas
  import puertas_pkg::*;
#(
  parameter int unsigned T_MOVE = 8,
  parameter int unsigned T_OPEN = 20,
  parameter int unsigned CW     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  motor_puertas_if.slave   bus
);

  localparam logic [CW-1:0] TMove   = CW'(T_MOVE);
  localparam logic [CW-1:0] TMoveM1 = CW'(T_MOVE - 1);
  localparam logic [CW-1:0] Uno     = CW'(1);

  puertas_e      state_q, state_d;
  motor_e        motor_q, motor_d;
  logic [CW-1:0] pos_q, pos_d;
  logic          dwell_clr, dwell_en;
  logic          cmd_abrir, cmd_cerrar;

  // Code 11 decodes as neither command, i.e. as NADA.
  assign cmd_abrir  = (bus.salida_puertas == ABRIR);
  assign cmd_cerrar = (bus.salida_puertas == CERRAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CERRADAS;
      motor_q <= MOTOR_OFF;
      pos_q   <= '0;
    end else begin
      state_q <= state_d;
      motor_q <= motor_d;
      pos_q   <= pos_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    dwell_clr = 1'b1;
    dwell_en  = 1'b0;
    unique case (state_q)
      CERRADAS: begin
        pos_d = '0;
        if (cmd_abrir) begin
          state_d = ABRIENDO;
        end
      end
      ABRIENDO: begin
        if (cmd_cerrar && !bus.sensor) begin
          state_d = CERRANDO;
        end else if (pos_q >= TMoveM1) begin
          state_d = ABIERTAS;
          pos_d   = TMove;
        end else begin
          pos_d = pos_q + Uno;
        end
      end
      ABIERTAS: begin
        // Obstruction or a fresh open command restarts the dwell and beats close.
        if (bus.sensor || cmd_abrir) begin
          state_d = ABIERTAS;
        end else if (cmd_cerrar) begin
          state_d = CERRANDO;
        end else begin
          dwell_clr = 1'b0;
          dwell_en  = 1'b1;
        end
      end
      CERRANDO: begin
        // Reversal keeps the current position and outranks reaching closed.
        if (bus.sensor || cmd_abrir) begin
          state_d = ABRIENDO;
        end else if (pos_q <= Uno) begin
          state_d = CERRADAS;
          pos_d   = '0;
        end else begin
          pos_d = pos_q - Uno;
        end
      end
    endcase
  end

  always_comb begin
    motor_d     = motor_de(state_d);
    bus.puertas = state_q;
    bus.motor   = motor_q;
  end

  temporizador_puertas #(
    .T_OPEN (T_OPEN),
    .CW     (CW)
  ) u_temporizador (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr_i     (dwell_clr),
    .en_i      (dwell_en),
    .timeout_o (bus.timeout)
  );

endmodule

// File: tb/tb_motor_puertas.sv
// Bench for motor_puertas with T_MOVE=4, T_OPEN=6: vector table, corner
// sequences and a randomized run against a position/direction door model.
module tb_motor_puertas;

  localparam int TM = 4;
  localparam int TO = 6;

  // {puertas, motor, timeout}
  localparam logic [4:0] E_CLOSED  = 5'b00_00_0;
  localparam logic [4:0] E_OPENING = 5'b11_01_0;
  localparam logic [4:0] E_OPEN    = 5'b01_00_0;
  localparam logic [4:0] E_OPEN_TO = 5'b01_00_1;
  localparam logic [4:0] E_CLOSING = 5'b10_10_0;

  typedef struct packed {
    logic [1:0] cmd;
    logic       sensor;
    logic [4:0] exp;
  } vec_t;

  logic clk;
  logic rst_n;
  int   n_checks = 0;
  int   n_pass   = 0;

  // Door model: position, travel direction (+1 opening, -1 closing, 0 still), dwell.
  int m_pos, m_dir, m_dwell;

  motor_puertas_if bus_if ();

  motor_puertas #(
    .T_MOVE (TM),
    .T_OPEN (TO),
    .CW     (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_pos = 0; m_dir = 0; m_dwell = 0;
  endtask

  task automatic model_step(input logic [1:0] cmd_raw, input logic s);
    int c;
    c = (cmd_raw == 2'b11) ? 0 : int'(cmd_raw);
    if (m_dir > 0) begin
      if (c == 2 && !s) m_dir = -1;
      else begin
        m_pos = m_pos + 1;
        if (m_pos >= TM) begin m_pos = TM; m_dir = 0; m_dwell = 0; end
      end
    end else if (m_dir < 0) begin
      if (s || c == 1) m_dir = 1;
      else begin
        m_pos = m_pos - 1;
        if (m_pos <= 0) begin m_pos = 0; m_dir = 0; end
      end
    end else if (m_pos == 0) begin
      if (c == 1) m_dir = 1;
    end else begin
      if (s || c == 1) m_dwell = 0;
      else if (c == 2) begin m_dir = -1; m_dwell = 0; end
      else if (m_dwell < TO) m_dwell = m_dwell + 1;
    end
  endtask

  function automatic logic [4:0] model_out();
    logic [1:0] p, m;
    logic       t;
    if (m_dir > 0) begin p = 2'b11; m = 2'b01; end
    else if (m_dir < 0) begin p = 2'b10; m = 2'b10; end
    else if (m_pos == TM) begin p = 2'b01; m = 2'b00; end
    else begin p = 2'b00; m = 2'b00; end
    t = (m_dir == 0) && (m_pos == TM) && (m_dwell == TO);
    return {p, m, t};
  endfunction

  task automatic check(input string name, input logic [4:0] exp);
    logic [4:0] act;
    act = {bus_if.puertas, bus_if.motor, bus_if.timeout};
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: puertas/motor/timeout got %b/%b/%b want %b/%b/%b", name,
                  act[4:3], act[2:1], act[0], exp[4:3], exp[2:1], exp[0]);
  endtask

  task automatic cycle(input logic [1:0] cmd, input logic s);
    bus_if.salida_puertas = cmd;
    bus_if.sensor         = s;
    @(posedge clk);
    model_step(cmd, s);
    #1;
  endtask

  vec_t vecs [24];

  initial begin
    vecs[0]  = '{2'b01, 1'b0, E_OPENING};
    vecs[1]  = '{2'b00, 1'b0, E_OPENING};
    vecs[2]  = '{2'b00, 1'b0, E_OPENING};
    vecs[3]  = '{2'b00, 1'b0, E_OPENING};
    vecs[4]  = '{2'b00, 1'b0, E_OPEN};
    vecs[5]  = '{2'b00, 1'b0, E_OPEN};
    vecs[6]  = '{2'b00, 1'b0, E_OPEN};
    vecs[7]  = '{2'b00, 1'b0, E_OPEN};
    vecs[8]  = '{2'b00, 1'b0, E_OPEN};
    vecs[9]  = '{2'b00, 1'b0, E_OPEN};
    vecs[10] = '{2'b00, 1'b0, E_OPEN_TO};
    vecs[11] = '{2'b00, 1'b0, E_OPEN_TO};
    vecs[12] = '{2'b10, 1'b0, E_CLOSING};
    vecs[13] = '{2'b00, 1'b0, E_CLOSING};
    vecs[14] = '{2'b00, 1'b0, E_CLOSING};
    vecs[15] = '{2'b00, 1'b0, E_CLOSING};
    vecs[16] = '{2'b00, 1'b0, E_CLOSED};
    vecs[17] = '{2'b11, 1'b0, E_CLOSED};
    vecs[18] = '{2'b10, 1'b0, E_CLOSED};
    vecs[19] = '{2'b00, 1'b1, E_CLOSED};
    vecs[20] = '{2'b01, 1'b1, E_OPENING};
    vecs[21] = '{2'b10, 1'b1, E_OPENING};
    vecs[22] = '{2'b10, 1'b0, E_CLOSING};
    vecs[23] = '{2'b00, 1'b0, E_CLOSED};

    bus_if.salida_puertas = 2'b00;
    bus_if.sensor         = 1'b0;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1 check("reset_state", E_CLOSED);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 24; i++) begin
      cycle(vecs[i].cmd, vecs[i].sensor);
      check($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Asynchronous reset while opening at pos=2.
    cycle(2'b01, 1'b0);
    cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b0);
    check("pre_reset_opening", E_OPENING);
    #2 rst_n = 1'b0;
    #1 check("async_reset_no_edge", E_CLOSED);
    @(posedge clk);
    #1 check("reset_held", E_CLOSED);
    #2 rst_n = 1'b1;
    model_reset();
    cycle(2'b00, 1'b0);
    check("after_release", E_CLOSED);

    // Reversal at pos=2 while closing.
    cycle(2'b01, 1'b0);
    repeat (4) cycle(2'b00, 1'b0);
    check("opened", E_OPEN);
    cycle(2'b10, 1'b0);
    cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b0);
    check("closing_pos2", E_CLOSING);
    cycle(2'b00, 1'b1);
    check("reversal", E_OPENING);
    cycle(2'b00, 1'b0);
    check("reversal_travel", E_OPENING);
    cycle(2'b00, 1'b0);
    check("reopened", E_OPEN);

    // Sensor beats close at dwell=5, dwell restarts.
    repeat (5) cycle(2'b00, 1'b0);
    check("dwell5_no_timeout", E_OPEN);
    cycle(2'b10, 1'b1);
    check("sensor_beats_close", E_OPEN);
    repeat (5) cycle(2'b00, 1'b0);
    check("dwell_restarted", E_OPEN);
    cycle(2'b00, 1'b0);
    check("timeout_after_sensor", E_OPEN_TO);
    cycle(2'b01, 1'b0);
    check("open_cmd_clears_timeout", E_OPEN);

    // Sensor while closing at pos=1 reverses instead of closing.
    cycle(2'b10, 1'b0);
    repeat (3) cycle(2'b00, 1'b0);
    check("closing_pos1", E_CLOSING);
    cycle(2'b00, 1'b1);
    check("collision_reverse", E_OPENING);
    cycle(2'b00, 1'b0);
    cycle(2'b00, 1'b0);
    check("collision_pos3", E_OPENING);
    cycle(2'b00, 1'b0);
    check("collision_open", E_OPEN);

    // Randomized run against the model, with occasional mid-cycle resets.
    for (int n = 0; n < 3000; n++) begin
      int r;
      logic [1:0] cmd;
      r = int'($urandom_range(0, 7));
      cmd = (r < 5) ? 2'b00 : (r == 5) ? 2'b01 : (r == 6) ? 2'b10 : 2'b11;
      cycle(cmd, ($urandom_range(0, 7) == 0));
      check("rand", model_out());
      if ($urandom_range(0, 299) == 0) begin
        #2 rst_n = 1'b0;
        model_reset();
        #1 check("rand_reset", model_out());
        @(posedge clk);
        #2 rst_n = 1'b1;
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
